// File: rtl/bar_scheduler.sv
// Bar-graph level scheduler: captures one target level per bar, then eases the displayed levels
// towards those targets in a one-bar-per-cycle pass during vertical blank.
// Optional peak-hold tracking is compiled in when BAR_PEAK_HOLD_EN is defined.
module bar_scheduler #(
    parameter int unsigned NUM_BARS = 80,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk_vga_i,
    input  logic       reset_i,
    input  logic       sample_valid_i,
    output logic       sample_ready_o,
    input  logic [9:0] wave_sample_i,
    input  logic       frame_start_i,
    input  logic [6:0] rd_idx_i,
    output logic [4:0] rd_vol_o,
    output logic [4:0] rd_peak_o,
    output logic       busy_o,
    output logic       overrun_o
);

    localparam int unsigned    IdxW    = $clog2(NUM_BARS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BARS - 1);
    localparam logic [5:0]     StepW   = 6'(STEP);

    typedef enum logic [0:0] {StCapture, StSmooth} state_e;

    state_e          state_q;
    logic [IdxW-1:0] wr_ptr_q;
    logic [IdxW-1:0] scan_q;
    logic            overrun_q;
    logic [4:0]      bin_q [NUM_BARS];
    logic [4:0]      vol_q [NUM_BARS];

    logic [4:0]      sample_bin;
    logic [4:0]      cur_bin;
    logic [4:0]      cur_vol;
    logic [5:0]      diff;
    logic [4:0]      vol_new;
    logic            rd_in_range;
    logic [IdxW-1:0] rd_sel;
    logic            unused_wave_lsbs;

    // Negative samples collapse to an empty bar.
    assign sample_bin       = wave_sample_i[9] ? wave_sample_i[8:4] : 5'd0;
    assign unused_wave_lsbs = ^wave_sample_i[3:0];

    // Move the bar being visited at most STEP towards its target; never overshoots.
    always_comb begin
        cur_bin = bin_q[scan_q];
        cur_vol = vol_q[scan_q];
        diff    = 6'd0;
        vol_new = cur_vol;
        if (cur_bin > cur_vol) begin
            diff    = {1'b0, cur_bin} - {1'b0, cur_vol};
            vol_new = (diff > StepW) ? cur_vol + StepW[4:0] : cur_bin;
        end else if (cur_bin < cur_vol) begin
            diff    = {1'b0, cur_vol} - {1'b0, cur_bin};
            vol_new = (diff > StepW) ? cur_vol - StepW[4:0] : cur_bin;
        end
    end

    always_ff @(posedge clk_vga_i) begin
        if (reset_i) begin
            state_q   <= StCapture;
            wr_ptr_q  <= '0;
            scan_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(NUM_BARS); i++) begin
                bin_q[i] <= '0;
                vol_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StCapture: begin
                    if (sample_valid_i) begin
                        bin_q[wr_ptr_q] <= sample_bin;
                        wr_ptr_q        <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + IdxW'(1);
                    end
                    if (frame_start_i) begin
                        state_q <= StSmooth;
                        scan_q  <= '0;
                    end
                end
                StSmooth: begin
                    vol_q[scan_q] <= vol_new;
                    // A new frame cannot restart an unfinished pass; just flag it.
                    if (frame_start_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (scan_q == LastIdx) begin
                        state_q <= StCapture;
                        scan_q  <= '0;
                    end else begin
                        scan_q <= scan_q + IdxW'(1);
                    end
                end
                default: state_q <= StCapture;
            endcase
        end
    end

    assign sample_ready_o = (state_q == StCapture);
    assign busy_o         = (state_q == StSmooth);
    assign overrun_o      = overrun_q;

    assign rd_in_range = (32'(rd_idx_i) < NUM_BARS);
    assign rd_sel      = rd_idx_i[IdxW-1:0];
    assign rd_vol_o    = rd_in_range ? vol_q[rd_sel] : 5'd0;

`ifdef BAR_PEAK_HOLD_EN
    logic [4:0] peak_q [NUM_BARS];
    logic [5:0] hcnt_q [NUM_BARS];

    // Peaks latch the new level, hold for 59 further passes, then decay one step per pass.
    always_ff @(posedge clk_vga_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NUM_BARS); i++) begin
                peak_q[i] <= '0;
                hcnt_q[i] <= '0;
            end
        end else if (state_q == StSmooth) begin
            if (vol_new >= peak_q[scan_q]) begin
                peak_q[scan_q] <= vol_new;
                hcnt_q[scan_q] <= 6'd59;
            end else if (hcnt_q[scan_q] != 6'd0) begin
                hcnt_q[scan_q] <= hcnt_q[scan_q] - 6'd1;
            end else begin
                peak_q[scan_q] <= (peak_q[scan_q] - 5'd1 > vol_new) ?
                                  peak_q[scan_q] - 5'd1 : vol_new;
            end
        end
    end

    assign rd_peak_o = rd_in_range ? peak_q[rd_sel] : 5'd0;
`else
    assign rd_peak_o = 5'd0;
`endif

endmodule

// File: tb/tb_bar_scheduler.sv
// Bench for bar_scheduler: two instances (STEP=1 and STEP=4) share one stimulus stream and are
// checked every cycle against a frame-level model, plus hand-computed literal expectations.
module tb_bar_scheduler;

    localparam int N = 80;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [9:0] wave;
    logic       frame_start;
    logic [6:0] rd_idx;
    logic       ready_a, busy_a, ovr_a, ready_b, busy_b, ovr_b;
    logic [4:0] vol_a, peak_a, vol_b, peak_b;

    always #5 clk = ~clk;

    bar_scheduler #(.NUM_BARS(N), .STEP(1)) u_dut_a (
        .clk_vga_i      (clk),
        .reset_i        (reset),
        .sample_valid_i (sample_valid),
        .sample_ready_o (ready_a),
        .wave_sample_i  (wave),
        .frame_start_i  (frame_start),
        .rd_idx_i       (rd_idx),
        .rd_vol_o       (vol_a),
        .rd_peak_o      (peak_a),
        .busy_o         (busy_a),
        .overrun_o      (ovr_a)
    );

    bar_scheduler #(.NUM_BARS(N), .STEP(4)) u_dut_b (
        .clk_vga_i      (clk),
        .reset_i        (reset),
        .sample_valid_i (sample_valid),
        .sample_ready_o (ready_b),
        .wave_sample_i  (wave),
        .frame_start_i  (frame_start),
        .rd_idx_i       (rd_idx),
        .rd_vol_o       (vol_b),
        .rd_peak_o      (peak_b),
        .busy_o         (busy_b),
        .overrun_o      (ovr_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a whole smoothing pass is applied at once when the frame is accepted;
    // displayed levels are compared only once the DUT is back in capture.
    int bin_m [N];
    int vol_m [2][N];
    int peak_m[2][N];
    int hcnt_m[2][N];
    int steps [2] = '{1, 4};
    int wr_m;
    int pass_left;
    bit ovr_m;
    bit checking = 1'b0;

    function automatic void model_pass();
        int nv;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < N; b++) begin
                if (bin_m[b] > vol_m[d][b])
                    nv = vol_m[d][b] + ((bin_m[b] - vol_m[d][b] > steps[d]) ?
                                        steps[d] : bin_m[b] - vol_m[d][b]);
                else
                    nv = vol_m[d][b] - ((vol_m[d][b] - bin_m[b] > steps[d]) ?
                                        steps[d] : vol_m[d][b] - bin_m[b]);
`ifdef BAR_PEAK_HOLD_EN
                if (nv >= peak_m[d][b]) begin
                    peak_m[d][b] = nv;
                    hcnt_m[d][b] = 59;
                end else if (hcnt_m[d][b] > 0) begin
                    hcnt_m[d][b] = hcnt_m[d][b] - 1;
                end else begin
                    peak_m[d][b] = (peak_m[d][b] - 1 > nv) ? peak_m[d][b] - 1 : nv;
                end
`endif
                vol_m[d][b] = nv;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < N; b++) begin
                bin_m[b] = 0;
                for (int d = 0; d < 2; d++) begin
                    vol_m[d][b]  = 0;
                    peak_m[d][b] = 0;
                    hcnt_m[d][b] = 0;
                end
            end
            wr_m      = 0;
            pass_left = 0;
            ovr_m     = 1'b0;
        end else if (pass_left > 0) begin
            pass_left = pass_left - 1;
            if (frame_start) ovr_m = 1'b1;
        end else begin
            if (sample_valid) begin
                bin_m[wr_m] = wave[9] ? int'(wave[8:4]) : 0;
                wr_m        = (wr_m + 1) % N;
            end
            if (frame_start) begin
                model_pass();
                pass_left = N;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("ready_a", 32'(ready_a), 32'(pass_left == 0));
            chk("ready_b", 32'(ready_b), 32'(pass_left == 0));
            chk("busy_a", 32'(busy_a), 32'(pass_left != 0));
            chk("busy_b", 32'(busy_b), 32'(pass_left != 0));
            chk("overrun_a", 32'(ovr_a), 32'(ovr_m));
            chk("overrun_b", 32'(ovr_b), 32'(ovr_m));
            if (pass_left == 0) begin
                chk("rd_vol_a", 32'(vol_a), (rd_idx < N) ? vol_m[0][rd_idx] : 0);
                chk("rd_vol_b", 32'(vol_b), (rd_idx < N) ? vol_m[1][rd_idx] : 0);
                chk("rd_peak_a", 32'(peak_a), (rd_idx < N) ? peak_m[0][rd_idx] : 0);
                chk("rd_peak_b", 32'(peak_b), (rd_idx < N) ? peak_m[1][rd_idx] : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_n(input int count, input int mag, input bit pos);
        for (int i = 0; i < count; i++) begin
            sample_valid = 1'b1;
            wave         = {pos, 5'(mag), 4'hA};
            tick();
        end
        sample_valid = 1'b0;
    endtask

    // Starts a pass and counts busy cycles; optional extra frame_start / reset at pass cycle k.
    task automatic run_frame(input int fs_at, input int rst_at, input bit hold_valid,
                             input bit with_sample, input int exp_len, input string name);
        int cnt = 0;
        frame_start  = 1'b1;
        sample_valid = with_sample;
        tick();
        frame_start  = 1'b0;
        sample_valid = hold_valid;
        if (hold_valid) wave = {1'b1, 5'd5, 4'h0};
        while (busy_a === 1'b1 && cnt < 200) begin
            frame_start = (cnt == fs_at);
            reset       = (cnt == rst_at);
            tick();
            cnt++;
        end
        frame_start  = 1'b0;
        reset        = 1'b0;
        sample_valid = 1'b0;
        chk(name, 32'(cnt), 32'(exp_len));
    endtask

    task automatic peek(input int idx, output logic [4:0] va, output logic [4:0] vb,
                        output logic [4:0] pa);
        rd_idx = 7'(idx);
        #1;
        va = vol_a;
        vb = vol_b;
        pa = peak_a;
    endtask

    task automatic sweep();
        for (int i = 0; i < 128; i++) begin
            rd_idx = 7'(i);
            tick();
        end
        rd_idx = 7'd0;
    endtask

    int exp_up[5] = '{8, 12, 16, 20, 20};
    int exp_dn[5] = '{16, 12, 8, 4, 0};

    initial begin
        logic [4:0] va, vb, pa;
        reset        = 1'b1;
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        wave         = '0;
        rd_idx       = '0;
        tick();
        checking = 1'b1;
        tick();
        reset = 1'b0;

        chk("reset_ready", 32'(ready_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_overrun", 32'(ovr_b), 32'd0);
        peek(17, va, vb, pa);
        chk("reset_vol", 32'(va), 32'd0);

        // 80 positive samples of magnitude 20, one pass
        send_n(N, 20, 1'b1);
        run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_first");
        peek(0, va, vb, pa);
        chk("first_vol_a_0", 32'(va), 32'd1);
        chk("first_vol_b_0", 32'(vb), 32'd4);
        peek(79, va, vb, pa);
        chk("first_vol_a_79", 32'(va), 32'd1);
        sweep();

        for (int f = 0; f < 5; f++) begin
            run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_up");
            peek(37, va, vb, pa);
            chk("ramp_up_b", 32'(vb), 32'(exp_up[f]));
        end
        send_n(N, 20, 1'b0);
        for (int f = 0; f < 5; f++) begin
            run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_dn");
            peek(52, va, vb, pa);
            chk("ramp_dn_b", 32'(vb), 32'(exp_dn[f]));
        end
        chk("ramp_dn_a", 32'(va), 32'd1);

        // Sample and frame_start in the same capture cycle
        do_reset();
        wave = {1'b1, 5'd31, 4'h3};
        run_frame(-1, -1, 1'b0, 1'b1, N, "pass_len_same_cycle");
        peek(0, va, vb, pa);
        chk("same_cycle_vol_a0", 32'(va), 32'd1);
        chk("same_cycle_vol_b0", 32'(vb), 32'd4);
        peek(1, va, vb, pa);
        chk("same_cycle_vol_a1", 32'(va), 32'd0);
        send_n(1, 10, 1'b1);
        run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_wrptr");
        peek(1, va, vb, pa);
        chk("wrptr_vol_a1", 32'(va), 32'd1);
        peek(0, va, vb, pa);
        chk("wrptr_vol_b0", 32'(vb), 32'd8);

        // Overrun: frame_start 10 cycles into the pass, sample held during the pass
        run_frame(10, -1, 1'b1, 1'b0, N, "pass_len_overrun");
        repeat (10) tick();
        chk("overrun_no_second_pass", 32'(busy_a), 32'd0);
        chk("overrun_set", 32'(ovr_a), 32'd1);
        run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_after_overrun");
        chk("overrun_sticky", 32'(ovr_b), 32'd1);

        // Reset in the middle of a pass
        run_frame(-1, 40, 1'b0, 1'b0, 41, "pass_len_reset_mid");
        chk("mid_reset_overrun", 32'(ovr_a), 32'd0);
        chk("mid_reset_ready", 32'(ready_b), 32'd1);
        peek(0, va, vb, pa);
        chk("mid_reset_vol_b0", 32'(vb), 32'd0);
        peek(100, va, vb, pa);
        chk("idx100_vol", 32'(va), 32'd0);
        sweep();

        // Peak hold: rise to 10, then drop to 0
        send_n(N, 10, 1'b1);
        for (int f = 0; f < 10; f++) run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_peak_up");
        peek(5, va, vb, pa);
        chk("peak_up_vol_a", 32'(va), 32'd10);
        send_n(N, 10, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            run_frame(-1, -1, 1'b0, 1'b0, N, "pass_len_peak_dn");
            peek(5, va, vb, pa);
`ifdef BAR_PEAK_HOLD_EN
            if (k == 59) chk("peak_hold_59", 32'(pa), 32'd10);
            if (k == 60) chk("peak_decay_60", 32'(pa), 32'd9);
            if (k == 69) chk("peak_decay_69", 32'(pa), 32'd0);
`else
            if (k == 59) chk("peak_off", 32'(pa), 32'd0);
`endif
        end
        chk("peak_dn_vol_a", 32'(va), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_scheduler.md
BAR_SCHEDULER -- requirements
Module: bar_scheduler

Interface
REQ-001 Parameter NUM_BARS, default 80: number of bar bins; legal range 2-128.
REQ-002 Parameter STEP, default 1: maximum per-frame change of a displayed level; legal range 1-31.
REQ-003 CLK_VGA  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 sample_valid  input  1  wave_sample is valid this cycle.
REQ-006 sample_ready  output  1  block accepts a sample this cycle.
REQ-007 wave_sample  input  10  signed-magnitude sample: bit 9 = positive, bits 8:4 = magnitude.
REQ-008 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-009 rd_idx  input  7  bar index requested by the draw logic.
REQ-010 rd_vol  output  5  displayed level of bar rd_idx; combinational read; 0 when rd_idx >= NUM_BARS.
REQ-011 rd_peak  output  5  peak-hold level of bar rd_idx; combinational read (see Configuration).
REQ-012 busy  output  1  high while in SMOOTH.
REQ-013 overrun  output  1  sticky: frame_start arrived while busy.

Function
REQ-014 Storage: bin[NUM_BARS] x 5 bits (captured target); vol[NUM_BARS] x 5 bits (displayed level).
REQ-015 FSM states: CAPTURE, SMOOTH; reset state CAPTURE.
REQ-016 CAPTURE: sample_ready=1; on sample_valid, bin[wr_ptr] <= wave_sample[9] ? wave_sample[8:4] : 0; wr_ptr increments.
REQ-017 wr_ptr wraps from NUM_BARS-1 to 0 on accept; it is not reset by frame boundaries.
REQ-018 CAPTURE with frame_start=1: go to SMOOTH next cycle; a sample accepted in the same cycle is written, and the SMOOTH pass uses the written value.
REQ-019 SMOOTH: sample_ready=0, busy=1; scan index j runs 0..NUM_BARS-1, one bar per cycle, starting at 0.
REQ-020 Per bar: d = bin[j] - vol[j]; if d>0 then vol[j] += min(d,STEP); if d<0 then vol[j] -= min(-d,STEP); if d=0 no change. Never wraps outside 0-31.
REQ-021 Pass length is exactly NUM_BARS cycles; after j = NUM_BARS-1, return to CAPTURE on the next cycle with j cleared.
REQ-022 frame_start during SMOOTH: ignored for sequencing; overrun <= 1.
REQ-023 sample_valid during SMOOTH: not accepted; bin and wr_ptr unchanged; the sender must hold the sample.
REQ-024 rd_vol may change within a frame only during SMOOTH; the pass runs in blanking, so the displayed frame does not tear.

Reset
REQ-025 RESET=1 at any clock edge, including mid-SMOOTH: state <= CAPTURE; wr_ptr, j, overrun <= 0; all bin, vol and peak entries <= 0.
REQ-026 Outputs during and after reset: sample_ready=1, busy=0, overrun=0, rd_vol=0, rd_peak=0.
REQ-027 RESET has priority over sample_valid and frame_start in the same cycle.

Configuration
REQ-028 Macro BAR_PEAK_HOLD_EN defined: add peak[NUM_BARS] x 5 bits and hold counter hcnt[NUM_BARS] x 6 bits.
REQ-029 Peak update, during the SMOOTH visit of bar j:
- if the new vol[j] >= peak[j], then peak[j] <= new vol and hcnt[j] <= 59;
- else if hcnt[j] > 0, then hcnt[j] -= 1;
- else peak[j] -= 1, floored at vol.
REQ-030 BAR_PEAK_HOLD_EN not defined: no peak storage; rd_peak is tied to 0; all other behaviour is identical.

Verification
REQ-031 Reset, then 80 positive samples (magnitude 20), then frame_start -> busy high for exactly 80 cycles; every rd_vol = 1 afterward; sample_ready = 0 throughout the pass.
REQ-032 STEP=4, bin=20, 6 frames -> rd_vol after each frame: 4, 8, 12, 16, 20, 20. Then bin=0 (negative samples) for 5 frames -> 16, 12, 8, 4, 0.
REQ-033 frame_start issued 10 cycles into SMOOTH -> pass still ends at cycle 80; no second pass; overrun = 1 and stays 1 until RESET.
REQ-034 sample_valid and frame_start in the same CAPTURE cycle, wr_ptr=0, magnitude 31 -> bin[0]=31 and vol[0]=1 after the pass; wr_ptr=1.
REQ-035 RESET asserted at pass cycle 40 -> next cycle: state CAPTURE, rd_vol=0 for all rd_idx, overrun=0; rd_idx=100 -> rd_vol=0.
REQ-036 With BAR_PEAK_HOLD_EN, vol reaches 10 then bin drops to 0 -> rd_peak stays 10 for 60 frames, then falls by 1 per frame until equal to vol; without the macro, rd_peak=0 always.
